// File: rtl/ladybird_bus_arbiter_pkg.sv
// Shared configuration for the ladybird bus arbiter:
// FSM state encoding and default timeout.
package ladybird_config;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } state_t;

  localparam int TIMEOUT_DEF = 255;
  localparam int TCNT_W      = 8;
endpackage

// File: rtl/ladybird_bus_arbiter_rr.sv
// Combinational round-robin picker: searches upward
// from last_owner+1 and returns one-hot grant plus index.
module ladybird_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_owner,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  always_comb begin
    int c;
    gnt = '0;
    idx = '0;
    c   = 0;
    // walk farthest-first so the nearest requester wins last
    for (int k = N; k >= 1; k--) begin
      c = (int'(last_owner) + k) % N;
      if (req[c]) begin
        gnt    = '0;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end
endmodule

// File: rtl/ladybird_bus_arbiter.sv
// Multi-master to single-slave bus arbiter with one
// outstanding transaction, response timeout and counters.
module ladybird_bus_arbiter
  import ladybird_config::*;
#(
  parameter int N_MASTER = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                            clk,
  input  logic                            arst,
  input  logic [N_MASTER-1:0]             m_req,
  input  logic [N_MASTER-1:0][ADDR_W-1:0] m_addr,
  input  logic [N_MASTER-1:0][DATA_W-1:0] m_wdata,
  input  logic [N_MASTER-1:0]             m_we,
  output logic [N_MASTER-1:0]             m_gnt,
  output logic [N_MASTER-1:0]             m_rvalid,
  output logic [DATA_W-1:0]               m_rdata,
  output logic                            m_rerr,
  output logic                            s_req,
  output logic [ADDR_W-1:0]               s_addr,
  output logic [DATA_W-1:0]               s_wdata,
  output logic                            s_we,
  input  logic                            s_gnt,
  input  logic                            s_rvalid,
  input  logic [DATA_W-1:0]               s_rdata,
  output logic [TCNT_W-1:0]               timeout_cnt
);
  localparam int IW = $clog2(N_MASTER);
  localparam int WW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] TO_V = WW'(TIMEOUT);

  state_t              state, state_n;
  logic [IW-1:0]       last_owner;
  logic [IW-1:0]       owner;
  logic [WW-1:0]       wcnt;
  logic [N_MASTER-1:0] rr_gnt;
  logic [IW-1:0]       rr_idx;
  logic                latch;
  logic                tout_hit;

  ladybird_rr_arbiter #(
    .N  (N_MASTER),
    .IW (IW)
  ) u_rr (
    .req        (m_req),
    .last_owner (last_owner),
    .gnt        (rr_gnt),
    .idx        (rr_idx)
  );

  assign tout_hit = (TIMEOUT > 0) && (wcnt == TO_V);

  always_comb begin
    state_n  = state;
    m_gnt    = '0;
    m_rvalid = '0;
    m_rdata  = '0;
    m_rerr   = 1'b0;
    s_req    = 1'b0;
    latch    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // gate with arst: grant is combinational from m_req
        if (!arst && (|m_req)) begin
          m_gnt   = rr_gnt;
          latch   = 1'b1;
          state_n = ST_REQ;
        end
      end
      ST_REQ: begin
        s_req = 1'b1;
        if (s_gnt) begin
          if (s_rvalid) begin
            m_rvalid[owner] = 1'b1;
            m_rdata         = s_rdata;
            state_n         = ST_IDLE;
          end else begin
            state_n = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (tout_hit) begin
          m_rvalid[owner] = 1'b1;
          m_rerr          = 1'b1;
          state_n         = ST_IDLE;
        end else if (s_rvalid) begin
          m_rvalid[owner] = 1'b1;
          m_rdata         = s_rdata;
          state_n         = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= ST_IDLE;
      last_owner  <= IW'(N_MASTER - 1);
      owner       <= '0;
      s_addr      <= '0;
      s_wdata     <= '0;
      s_we        <= 1'b0;
      wcnt        <= '0;
      timeout_cnt <= '0;
    end else begin
      state <= state_n;
      if (latch) begin
        owner      <= rr_idx;
        last_owner <= rr_idx;
        s_addr     <= m_addr[rr_idx];
        s_wdata    <= m_wdata[rr_idx];
        s_we       <= m_we[rr_idx];
      end
      // held clear while in REQ so RESP always starts at zero
      if (state == ST_REQ) begin
        wcnt <= '0;
      end else if (state == ST_RESP && !s_rvalid
                   && !tout_hit) begin
        wcnt <= wcnt + WW'(1);
      end
      if (state == ST_RESP && tout_hit
          && timeout_cnt != '1) begin
        timeout_cnt <= timeout_cnt + TCNT_W'(1);
      end
    end
  end
endmodule

// File: doc/ladybird_bus_arbiter.md
LADYBIRD_BUS_ARBITER -- requirements
Module: ladybird_bus_arbiter

Interface
REQ-001 Parameters SHALL be:
- N_MASTER, default 2, number of requesting masters (2..8).
- ADDR_W, default 32, address width.
- DATA_W, default 32, data width.
- TIMEOUT, default 255, maximum response wait in cycles; 0 disables the timeout.

REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all logic on its rising edge.
- arst  in  1  asynchronous, active-high reset.
- m_req  in  N_MASTER  per-master request, held until granted.
- m_addr  in  N_MASTER x ADDR_W  per-master address.
- m_wdata  in  N_MASTER x DATA_W  per-master write data.
- m_we  in  N_MASTER  per-master write enable (1 = write).
- m_gnt  out  N_MASTER  one-cycle request-accept pulse.
- m_rvalid  out  N_MASTER  one-cycle response pulse to the owning master.
- m_rdata  out  DATA_W  response data, shared by all masters.
- m_rerr  out  1  response is a timeout error; qualified by m_rvalid.
- s_req  out  1  slave request.
- s_addr  out  ADDR_W  slave address.
- s_wdata  out  DATA_W  slave write data.
- s_we  out  1  slave write enable.
- s_gnt  in  1  slave accept.
- s_rvalid  in  1  slave response (reads and writes).
- s_rdata  in  DATA_W  slave read data.
- timeout_cnt  out  8  saturating count of timed-out transactions.

Function
REQ-003 The FSM SHALL have three states: IDLE, REQ, RESP; only one transaction is outstanding at a time.
REQ-004 In IDLE with any m_req set, the arbiter SHALL select the owner round-robin, starting the search at (last_owner+1) mod N_MASTER.
REQ-005 In that same IDLE cycle, the arbiter SHALL pulse m_gnt[owner], latch m_addr/m_wdata/m_we[owner] and the owner index, and move to REQ on the next edge.
REQ-006 After a grant, last_owner SHALL update to the owner.
REQ-007 In REQ, s_req SHALL be 1 with the latched fields held stable until s_gnt=1; then the FSM moves to RESP.
REQ-008 In REQ, s_gnt=1 together with s_rvalid=1 SHALL complete the transaction directly: forward the response and return to IDLE.
REQ-009 In RESP, m_rvalid[owner]=s_rvalid and m_rdata=s_rdata combinationally, with m_rerr=0; the edge after s_rvalid=1 SHALL return the FSM to IDLE.
REQ-010 Zero-wait latency SHALL be: gnt at cycle t, s_req at t+1, response forwarded at t+2.
REQ-011 The wait counter SHALL clear on entry to RESP and increment each RESP cycle without s_rvalid.
REQ-012 When the wait counter reaches TIMEOUT (TIMEOUT>0), the arbiter SHALL pulse m_rvalid[owner] with m_rerr=1 and m_rdata=0, increment timeout_cnt (saturating at 255), and return to IDLE.
REQ-013 s_rvalid arriving in IDLE (late response) SHALL be ignored: no m_rvalid.
REQ-014 m_gnt and m_rvalid SHALL each be at most one-hot; non-owners SHALL never receive m_rvalid.
REQ-015 m_req deasserted before its grant SHALL be dropped without side effects.
REQ-016 Outside REQ, s_req SHALL be 0; outside a response cycle, m_rdata SHALL be 0.

Reset
REQ-017 While arst=1, the block SHALL be in IDLE with last_owner=N_MASTER-1, so master 0 wins first.
REQ-018 While arst=1, the wait counter and timeout_cnt SHALL be 0, and every output SHALL be 0.
REQ-019 arst asserted mid-transaction SHALL abort it immediately with no m_rvalid, and the slave response SHALL not be replayed after reset.

Structure
REQ-020 The FSM state typedef and the default TIMEOUT constant SHALL live in the shared ladybird_config package.
REQ-021 The round-robin priority picker SHALL be sub-module ladybird_rr_arbiter: inputs req vector and last_owner, outputs one-hot grant and index, combinational.
REQ-022 The latching, FSM and counters SHALL reside in ladybird_bus_arbiter.

Verification
REQ-023 Bench scenario, single read: master 0 reads 0x9000_0000; slave grants at once and returns 0xDEAD_BEEF after 3 cycles -> m_gnt[0] at t, s_req at t+1..t+1, m_rvalid[0] with 0xDEAD_BEEF at t+5, m_rerr=0.
REQ-024 Bench scenario, contention: m_req=2'b11 held continuously, instant slave -> grants alternate 0,1,0,1; each master served every second transaction.
REQ-025 Bench scenario, timeout: TIMEOUT=4, slave grants but never responds -> m_rvalid[owner] with m_rerr=1 and m_rdata=0 after 4 RESP cycles; timeout_cnt=1; a late s_rvalid is ignored.
REQ-026 Bench scenario, same-cycle completion: s_gnt and s_rvalid high together in REQ -> response forwarded that cycle; next request granted the following cycle.
REQ-027 Bench scenario, reset mid-RESP: arst pulsed during RESP -> all outputs 0 immediately; after release, master 0 is granted first.
REQ-028 Bench scenario, N_MASTER=4: m_req=4'b1010 with last_owner=1 -> master 3 granted, then master 1.
